ext_unit_pipe: RTL and testbench

Parametrised, pipelined immediate/load-data extension unit. Replaces the purely combinational 16→32 zero/sign extender with a generic IN_W→OUT_W extender that also supports upper-immediate (LUI) placement and byte/halfword lane extraction for load alignment. Results are buffered in a DEPTH-entry output FIFO under a valid/ready handshake. It sits between decode/memory-read and the ALU operand or writeback mux.

---
 rtl/ext_unit_pipe.sv | 123 ++++++++++++
 tb/tb_ext_unit_pipe.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: IN_W->OUT_W immediate / load-lane extender with a DEPTH-entry output FIFO.
// Latency 1 cycle into an empty FIFO; in_ready depends only on registered occupancy.
module ext_unit_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2,
  parameter int ERRW  = 8,
  localparam int LANES = IN_W / 8,
  localparam int SELW  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       in_mode,
  input  logic [SELW-1:0]  in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [ERRW-1:0]  err_cnt
);

  localparam bit HAS_HALF = (IN_W >= 16);
  localparam int HALVES   = HAS_HALF ? (IN_W / 16) : 1;
  localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW       = $clog2(DEPTH + 1);

  logic [IN_W+15:0] wide;
  logic [7:0]       byte_l;
  logic [15:0]      half_l;
  logic [OUT_W-1:0] res;
  logic             res_err;
  int               lane;
  int               hidx;

  assign wide = {16'b0, in_data};

  always_comb begin
    lane   = int'(in_sel) % LANES;
    hidx   = (int'(in_sel) >> 1) % HALVES;
    byte_l = 8'(in_data >> (8 * lane));
    half_l = 16'(wide >> (16 * hidx));
  end

  // Narrow inputs have no halfword lane, so the half modes fall back to the byte lane.
  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (in_mode)
      3'd0: res = OUT_W'(in_data);
      3'd1: res = OUT_W'($signed(in_data));
      3'd2: res = OUT_W'(in_data) << (OUT_W - IN_W);
      3'd3: res = OUT_W'($signed(byte_l));
      3'd4: res = OUT_W'(byte_l);
      3'd5: begin
        if (HAS_HALF) res = OUT_W'($signed(half_l));
        else          res = OUT_W'($signed(byte_l));
      end
      3'd6: begin
        if (HAS_HALF) res = OUT_W'(half_l);
        else          res = OUT_W'(byte_l);
      end
      default: begin
        res     = '0;
        res_err = 1'b1;
      end
    endcase
  end

  logic [OUT_W-1:0] mem_d [DEPTH];
  logic             mem_e [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (cnt < CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign out_data  = mem_d[rd_ptr];
  assign out_err   = mem_e[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      err_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_e[i] <= 1'b0;
      end
    end else if (flush) begin
      // A coincident transfer-in is dropped entirely, error count included.
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr] <= res;
        mem_e[wr_ptr] <= res_err;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push && res_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Directed bench for ext_unit_pipe: extension modes, FIFO backpressure, flush, reset,
// plus a second ERRW=2 instance for error-counter saturation.
module tb_ext_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [15:0] in_data;
  logic [2:0]  in_mode;
  logic [0:0]  in_sel;
  logic [31:0] out_data;
  logic [7:0]  err_cnt;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_err;
  logic [31:0] s_out_data;
  logic [1:0]  s_err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ext_unit_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2), .ERRW(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  ext_unit_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2), .ERRW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(16'hFFFF),
    .in_mode(3'd7), .in_sel(1'b0),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
    .out_err(s_out_err), .err_cnt(s_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single push into an empty FIFO with out_ready high; result visible after the edge,
  // popped at the following edge.
  task automatic push_one(input string tag, input logic [15:0] d, input logic [2:0] m,
                          input logic s, input logic [31:0] exp, input logic exp_err);
    in_data = d; in_mode = m; in_sel = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_dat"}, out_data, exp);
    chk({tag, "_err"}, {31'b0, out_err}, {31'b0, exp_err});
    step();
    chk({tag, "_pop"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_mode = '0; in_sel = '0; s_in_valid = 1'b0;
    step(); step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_out_err",   {31'b0, out_err},   32'd0);
    chk("rst_err_cnt",   {24'b0, err_cnt},   32'd0);

    rst_n = 1'b1; out_ready = 1'b1;
    push_one("zero",   16'h8EF0, 3'd0, 1'b0, 32'h00008EF0, 1'b0);
    push_one("sign",   16'h8EF0, 3'd1, 1'b0, 32'hFFFF8EF0, 1'b0);
    push_one("sign_p", 16'h7EF0, 3'd1, 1'b0, 32'h00007EF0, 1'b0);
    push_one("upper",  16'h0004, 3'd2, 1'b0, 32'h00040000, 1'b0);
    push_one("bs0",    16'h80F0, 3'd3, 1'b0, 32'hFFFFFFF0, 1'b0);
    push_one("bz0",    16'h80F0, 3'd4, 1'b0, 32'h000000F0, 1'b0);
    push_one("bs1",    16'h80F0, 3'd3, 1'b1, 32'hFFFFFF80, 1'b0);
    push_one("bz1",    16'h80F0, 3'd4, 1'b1, 32'h00000080, 1'b0);
    push_one("hz0",    16'h80F0, 3'd6, 1'b0, 32'h000080F0, 1'b0);
    push_one("hs1",    16'h80F0, 3'd5, 1'b1, 32'hFFFF80F0, 1'b0);

    // Backpressure: fill, refuse a third word, then drain with push/pop overlap.
    out_ready = 1'b0; in_mode = 3'd0; in_sel = 1'b0;
    in_data = 16'h0001; in_valid = 1'b1;
    step();
    chk("bp_ready1", {31'b0, in_ready}, 32'd1);
    in_data = 16'h0002;
    step();
    chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_head1", out_data, 32'h00000001);
    in_data = 16'h0003;
    step();
    chk("bp_refused_head", out_data, 32'h00000001);
    chk("bp_refused_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("full_pop_head2", out_data, 32'h00000002);
    chk("full_pop_ready", {31'b0, in_ready}, 32'd1);
    chk("full_pop_vld", {31'b0, out_valid}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("pushpop_head3", out_data, 32'h00000003);
    chk("pushpop_vld", {31'b0, out_valid}, 32'd1);
    chk("pushpop_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("drain_empty", {31'b0, out_valid}, 32'd0);

    // Reserved mode.
    push_one("rsv1", 16'hFFFF, 3'd7, 1'b0, 32'h0, 1'b1);
    push_one("rsv2", 16'h1234, 3'd7, 1'b1, 32'h0, 1'b1);
    push_one("rsv3", 16'h8000, 3'd7, 1'b0, 32'h0, 1'b1);
    chk("err_cnt3", {24'b0, err_cnt}, 32'd3);

    // Saturation on the ERRW=2 instance.
    s_in_valid = 1'b1;
    step(); step();
    chk("sat_cnt2", {30'b0, s_err_cnt}, 32'd2);
    chk("sat_head_err", {31'b0, s_out_err}, 32'd1);
    step(); step(); step();
    s_in_valid = 1'b0;
    chk("sat_cnt3", {30'b0, s_err_cnt}, 32'd3);

    // Flush with two entries plus an offered word.
    out_ready = 1'b0; in_mode = 3'd0; in_data = 16'h00AA; in_valid = 1'b1;
    step(); step();
    chk("fl_full", {31'b0, in_ready}, 32'd0);
    flush = 1'b1; in_mode = 3'd7;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_vld", {31'b0, out_valid}, 32'd0);
    chk("fl_ready", {31'b0, in_ready}, 32'd1);
    chk("fl_err_cnt", {24'b0, err_cnt}, 32'd3);

    // Flush at count=1 with an accepted reserved-mode push: push and its count discarded.
    in_mode = 3'd0; in_valid = 1'b1;
    step();
    in_mode = 3'd7; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_vld", {31'b0, out_valid}, 32'd0);
    chk("fl1_err_cnt", {24'b0, err_cnt}, 32'd3);

    // Reset mid-stream.
    in_mode = 3'd0; in_data = 16'h1234; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pre_rst_head", out_data, 32'h00001234);
    rst_n = 1'b0;
    step();
    chk("mrst_vld", {31'b0, out_valid}, 32'd0);
    chk("mrst_ready", {31'b0, in_ready}, 32'd1);
    chk("mrst_data", out_data, 32'd0);
    chk("mrst_err", {31'b0, out_err}, 32'd0);
    chk("mrst_err_cnt", {24'b0, err_cnt}, 32'd0);
    chk("mrst_sat_cnt", {30'b0, s_err_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
